// File: rtl/score_text_buffer.sv
// Score text buffer: a 16x16 character-code store feeding the font ROM.
// A small sequencer blanks the buffer after reset and renders the two
// player scores as ASCII digits (double-dabble conversion) on request.
module score_text_buffer #(
  parameter int         SCORE_ROW  = 0,
  parameter int         L_COL      = 2,
  parameter int         R_COL      = 11,
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic [7:0] score_l,
  input  logic [7:0] score_r,
  input  logic       score_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    CONV_L,
    WR_L,
    CONV_R,
    WR_R,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  // Step counter: clear address, conversion step or digit index
  logic [7:0]  cnt;

  // Double-dabble register: [19:8] BCD digits, [7:0] binary being shifted out
  logic [19:0] sr;
  logic [19:0] sr_adj;

  logic [7:0]  work_r;
  logic [7:0]  pend_l;
  logic [7:0]  pend_r;
  logic        pend_flag;

  logic [6:0]  mem [256];

  logic        we;
  logic [7:0]  waddr;
  logic [6:0]  wdata;
  logic [3:0]  col;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;

  assign hund = sr[19:16];
  assign tens = sr[15:12];
  assign ones = sr[11:8];

  // Add-3 correction of every BCD nibble that has reached 5
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr[8 + 4*k +: 4] >= 4'd5) begin
        sr_adj[8 + 4*k +: 4] = sr[8 + 4*k +: 4] + 4'd3;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      CLEAR:   if (cnt == 8'd255) state_nx = IDLE;
      IDLE:    if (score_valid || pend_flag) state_nx = CONV_L;
      CONV_L:  if (cnt == 8'd7) state_nx = WR_L;
      WR_L:    if (cnt == 8'd2) state_nx = CONV_R;
      CONV_R:  if (cnt == 8'd7) state_nx = WR_R;
      WR_R:    if (cnt == 8'd2) state_nx = DONE;
      DONE:    state_nx = pend_flag ? CONV_L : IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // Step counter restarts at zero on every state change
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (state_nx != state) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Score capture, pending request and double-dabble datapath
  always_ff @(posedge pclk) begin
    if (rst) begin
      sr        <= 20'd0;
      work_r    <= 8'd0;
      pend_l    <= 8'd0;
      pend_r    <= 8'd0;
      pend_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (score_valid) begin
            sr        <= {12'd0, score_l};
            work_r    <= score_r;
            pend_flag <= 1'b0;
          end else if (pend_flag) begin
            sr        <= {12'd0, pend_l};
            work_r    <= pend_r;
            pend_flag <= 1'b0;
          end
        end
        CONV_L, CONV_R: sr <= sr_adj << 1;
        WR_L: if (cnt == 8'd2) sr <= {12'd0, work_r};
        DONE: begin
          if (pend_flag) begin
            sr        <= {12'd0, pend_l};
            work_r    <= pend_r;
            pend_flag <= 1'b0;
          end
        end
        default: ;
      endcase
      // A request arriving mid-update overrides any older pending one
      if (score_valid && (state != CLEAR) && (state != IDLE)) begin
        pend_l    <= score_l;
        pend_r    <= score_r;
        pend_flag <= 1'b1;
      end
    end
  end

  // Write port: blanking sweep during CLEAR, digit writes during WR_*
  always_comb begin
    we    = 1'b0;
    waddr = 8'd0;
    wdata = BLANK_CODE;
    col   = ((state == WR_L) ? 4'(L_COL) : 4'(R_COL)) + {2'b00, cnt[1:0]};
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
      end
      WR_L, WR_R: begin
        we    = 1'b1;
        waddr = {4'(SCORE_ROW), col};
        case (cnt[1:0])
          2'd0:    wdata = (hund == 4'd0) ? BLANK_CODE : {3'b011, hund};
          2'd1:    wdata = ((hund == 4'd0) && (tens == 4'd0)) ? BLANK_CODE : {3'b011, tens};
          default: wdata = {3'b011, ones};
        endcase
      end
      default: ;
    endcase
  end

  // Buffer write
  always_ff @(posedge pclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to the same cell is not yet visible
  always_ff @(posedge pclk) begin
    if (rst) begin
      char_code <= 7'h00;
    end else begin
      char_code <= mem[char_xy];
    end
  end

endmodule

// File: tb/tb_score_text_buffer.sv
// Self-checking bench for score_text_buffer: clear sweep, table of score
// renders, read/write collisions, queued requests and mid-update reset.
module tb_score_text_buffer;

  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic       score_valid;
  logic       busy;
  logic       done;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] model [256];

  logic [7:0] s_addr [6];
  logic [6:0] s_data [6];
  int         s_edge [6];
  int         n_sched = 0;

  typedef struct {
    logic [7:0] addr;
    logic [6:0] exp;
  } rd_t;
  rd_t rd_q[$];

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  r;
    logic [20:0] el;
    logic [20:0] er;
    int          mode;
    logic [7:0]  base;
  } vec_t;
  vec_t vecs [5];

  score_text_buffer dut (
    .pclk        (pclk),
    .rst         (rst),
    .char_xy     (char_xy),
    .char_code   (char_code),
    .score_l     (score_l),
    .score_r     (score_r),
    .score_valid (score_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 pclk = ~pclk;

  // Edge counter used to time reads against scheduled writes
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value a read sampled at edge e should return, honouring read-before-write
  function automatic logic [6:0] exp_at(input logic [7:0] a, input int e);
    logic [6:0] v;
    v = model[a];
    for (int i = 0; i < n_sched; i++) begin
      if (s_addr[i] == a && s_edge[i] < e) v = s_data[i];
    end
    return v;
  endfunction

  task automatic issue_read(input logic [7:0] a);
    rd_t t;
    char_xy = a;
    t.addr  = a;
    t.exp   = exp_at(a, cyc + 1);
    rd_q.push_back(t);
  endtask

  task automatic retire_read();
    rd_t t;
    if (rd_q.size() > 0) begin
      t = rd_q.pop_front();
      check_output($sformatf("read[%02h]", t.addr), char_code, t.exp);
    end
  endtask

  task automatic read_one(input logic [7:0] a, input logic [6:0] exp);
    @(negedge pclk);
    char_xy = a;
    @(negedge pclk);
    check_output($sformatf("cell[%02h]", a), char_code, exp);
  endtask

  task automatic sweep_all();
    for (int i = 0; i <= 256; i++) begin
      @(negedge pclk);
      retire_read();
      if (i < 256) issue_read(i[7:0]);
    end
  endtask

  task automatic schedule(input int n, input logic [20:0] el, input logic [20:0] er);
    n_sched = 6;
    for (int k = 0; k < 3; k++) begin
      s_addr[k]     = 8'(2 + k);
      s_data[k]     = el[20 - 7*k -: 7];
      s_edge[k]     = n + 9 + k;
      s_addr[k + 3] = 8'(11 + k);
      s_data[k + 3] = er[20 - 7*k -: 7];
      s_edge[k + 3] = n + 20 + k;
    end
  endtask

  task automatic commit();
    for (int i = 0; i < n_sched; i++) model[s_addr[i]] = s_data[i];
    n_sched = 0;
  endtask

  task automatic check_row(input logic [20:0] el, input logic [20:0] er);
    for (int k = 0; k < 3; k++) begin
      read_one(8'(2 + k), el[20 - 7*k -: 7]);
      read_one(8'(11 + k), er[20 - 7*k -: 7]);
    end
  endtask

  // Reset, then expect exactly 256 busy cycles with no done pulse
  task automatic do_reset();
    int r;
    @(negedge pclk);
    rst         = 1'b1;
    score_valid = 1'b0;
    @(negedge pclk);
    r   = cyc;
    rst = 1'b0;
    check_output("reset_char_code", char_code, 7'h00);
    check_output("reset_busy", busy, 1'b1);
    check_output("reset_done", done, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      @(negedge pclk);
      check_output("clear_busy", busy, (cyc <= r + 255));
      check_output("clear_done", done, 1'b0);
    end
    for (int a = 0; a < 256; a++) model[a] = 7'h20;
    n_sched = 0;
  endtask

  // One update from IDLE; mode 1 sweeps char_xy from base, mode 2 holds it at base
  task automatic apply_stimulus(input logic [7:0] l, input logic [7:0] r,
                                input logic [20:0] el, input logic [20:0] er,
                                input int mode, input logic [7:0] base);
    int n;
    @(negedge pclk);
    score_l     = l;
    score_r     = r;
    score_valid = 1'b1;
    n           = cyc + 1;
    schedule(n, el, er);
    if (mode != 0) issue_read(base);
    for (int i = 1; i <= 24; i++) begin
      @(negedge pclk);
      score_valid = 1'b0;
      score_l     = 8'($urandom);
      score_r     = 8'($urandom);
      retire_read();
      check_output("upd_busy", busy, (cyc <= n + 22));
      check_output("upd_done", done, (cyc == n + 22));
      if (i <= 23) begin
        if (mode == 1) issue_read(base + i[7:0]);
        else if (mode == 2) issue_read(base);
      end
    end
    commit();
  endtask

  // Two requests queued behind a running update; only the latest survives
  task automatic pending_test();
    int n;
    @(negedge pclk);
    score_l     = 8'd50;
    score_r     = 8'd60;
    score_valid = 1'b1;
    n           = cyc + 1;
    for (int i = 1; i <= 47; i++) begin
      @(negedge pclk);
      score_valid = 1'b0;
      score_l     = 8'($urandom);
      score_r     = 8'($urandom);
      if (i == 3) begin
        score_l     = 8'd1;
        score_r     = 8'd2;
        score_valid = 1'b1;
      end
      if (i == 6) begin
        score_l     = 8'd3;
        score_r     = 8'd4;
        score_valid = 1'b1;
      end
      check_output("pend_busy", busy, (cyc <= n + 45));
      check_output("pend_done", done, (cyc == n + 22 || cyc == n + 45));
    end
    score_valid = 1'b0;
    check_row({7'h20, 7'h20, 7'h33}, {7'h20, 7'h20, 7'h34});
    model[2]  = 7'h20; model[3]  = 7'h20; model[4]  = 7'h33;
    model[11] = 7'h20; model[12] = 7'h20; model[13] = 7'h34;
  endtask

  // Reset asserted partway into the left-digit writes
  task automatic abort_test();
    int n;
    @(negedge pclk);
    score_l     = 8'd123;
    score_r     = 8'd45;
    score_valid = 1'b1;
    n           = cyc + 1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge pclk);
      score_valid = 1'b0;
      check_output("abort_busy", busy, 1'b1);
      check_output("abort_done", done, 1'b0);
    end
    if (cyc != n + 8) check_output("abort_timing", cyc, n + 8);
    do_reset();
  endtask

  initial begin
    rst         = 1'b0;
    score_valid = 1'b0;
    char_xy     = 8'd0;
    score_l     = 8'd0;
    score_r     = 8'd0;

    vecs[0] = '{8'd7,   8'd0,   {7'h20, 7'h20, 7'h37}, {7'h20, 7'h20, 7'h30}, 2, 8'd4};
    vecs[1] = '{8'd255, 8'd100, {7'h32, 7'h35, 7'h35}, {7'h31, 7'h30, 7'h30}, 1, 8'd249};
    vecs[2] = '{8'd10,  8'd9,   {7'h20, 7'h31, 7'h30}, {7'h20, 7'h20, 7'h39}, 1, 8'd247};
    vecs[3] = '{8'd0,   8'd200, {7'h20, 7'h20, 7'h30}, {7'h32, 7'h30, 7'h30}, 0, 8'd0};
    vecs[4] = '{8'd99,  8'd105, {7'h20, 7'h39, 7'h39}, {7'h31, 7'h30, 7'h35}, 0, 8'd0};

    repeat (2) @(negedge pclk);
    do_reset();
    sweep_all();

    for (int v = 0; v < 5; v++) begin
      apply_stimulus(vecs[v].l, vecs[v].r, vecs[v].el, vecs[v].er, vecs[v].mode, vecs[v].base);
      check_row(vecs[v].el, vecs[v].er);
      if (v == 0) sweep_all();
    end

    pending_test();
    sweep_all();

    abort_test();
    sweep_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
